io_input_port: RTL and testbench

//  Input side of the memory-mapped board I/O; the seven-segment display is the output side.
//  - Samples the raw buttons A, B and calc, plus the 16 switches.
//  - Synchronises and debounces them, and latches button-press events.
//  - Serves the results as read-only words at data addresses 0x20/0x24/0x28/0x2c on the data bus.
//  - Sits beside data_ram. The MEM-stage read mux selects this block's data_o for those addresses.

---
 rtl/io_input_port_pkg.sv | 21 ++
 rtl/debounce_cell.sv | 41 ++++
 rtl/io_input_port.sv | 96 +++++++++
 tb/tb_io_input_port.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/io_input_port_pkg.sv
// Address map and bit layout of the board input words.
// Constants only; no latency and no backpressure.
package io_input_port_pkg;

  localparam logic [5:0] IoAddrBtnA   = 6'h20;
  localparam logic [5:0] IoAddrBtnB   = 6'h24;
  localparam logic [5:0] IoAddrCalc   = 6'h28;
  localparam logic [5:0] IoAddrSwitch = 6'h2c;

  localparam int IoEvtBit = 1;
  localparam int IoLvlBit = 0;

  function automatic logic [31:0] btn_word(input logic lvl, input logic evt);
    logic [31:0] w;
    w           = '0;
    w[IoEvtBit] = evt;
    w[IoLvlBit] = lvl;
    return w;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One-bit debouncer: accepts a new level after STABLE_CNT differing sample ticks.
// stable is registered; rise pulses one clk, in the first cycle stable reads 1. No backpressure.
module debounce_cell #(
  parameter int STABLE_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sync_in,
  output logic stable,
  output logic rise
);

  localparam int CW = $clog2(STABLE_CNT);

  logic [CW-1:0] cnt;
  logic          stable_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
      if (tick) begin
        if (sync_in == stable) begin
          cnt <= '0;
        end else if (cnt == CW'(STABLE_CNT - 1)) begin
          stable <= sync_in;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign rise = stable & ~stable_d;

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped board inputs: sync, debounce, sticky press events, read-only bus words.
// 2 clk sync + up to STABLE_CNT*SAMPLE_DIV debounce; data_o is combinational, never stalls.
module io_input_port
  import io_input_port_pkg::*;
#(
  parameter int SAMPLE_DIV = 1000,
  parameter int STABLE_CNT = 4,
  parameter int SW_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            we,
  input  logic [31:0]     addr,
  input  logic            btn_a,
  input  logic            btn_b,
  input  logic            btn_calc,
  input  logic [SW_W-1:0] switch,
  output logic [31:0]     data_o,
  output logic [2:0]      lvl_o,
  output logic [SW_W-1:0] sw_o
);

  localparam int NB = 3 + SW_W;

  logic [NB-1:0] raw, sync1, sync2, stable, rise;
  logic [15:0]   pre;
  logic          tick;
  logic [2:0]    evt, clr;
  logic [3:0]    word;
  logic          rd;
  logic          unused_bits;

  assign raw = {switch, btn_calc, btn_b, btn_a};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign tick = (pre == 16'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 16'd1;
  end

  for (genvar i = 0; i < NB; i++) begin : g_db
    debounce_cell #(.STABLE_CNT(STABLE_CNT)) u_db (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .sync_in(sync2[i]),
      .stable (stable[i]),
      .rise   (rise[i])
    );
  end

  assign word = addr[5:2];
  assign rd   = ce & ~we;

  assign clr[0] = rd && (word == IoAddrBtnA[5:2]);
  assign clr[1] = rd && (word == IoAddrBtnB[5:2]);
  assign clr[2] = rd && (word == IoAddrCalc[5:2]);

  // A new press in the same clk as a clearing read must survive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) evt <= '0;
    else      evt <= rise[2:0] | (evt & ~clr);
  end

  always_comb begin
    data_o = '0;
    if (rd) begin
      case (word)
        IoAddrBtnA[5:2]:   data_o = btn_word(stable[0], evt[0]);
        IoAddrBtnB[5:2]:   data_o = btn_word(stable[1], evt[1]);
        IoAddrCalc[5:2]:   data_o = btn_word(stable[2], evt[2]);
        IoAddrSwitch[5:2]: data_o = 32'(stable[NB-1:3]);
        default:           data_o = '0;
      endcase
    end
  end

  assign lvl_o = stable[2:0];
  assign sw_o  = stable[NB-1:3];

  assign unused_bits = ^{addr[31:6], addr[1:0], rise[NB-1:3]};

endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port with SAMPLE_DIV=4, STABLE_CNT=3, SW_W=16.
module tb_io_input_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [31:0] addr;
  logic        btn_a, btn_b, btn_calc;
  logic [15:0] switch;
  logic [31:0] data_o;
  logic [2:0]  lvl_o;
  logic [15:0] sw_o;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  io_input_port #(.SAMPLE_DIV(4), .STABLE_CNT(3), .SW_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .we      (we),
    .addr    (addr),
    .btn_a   (btn_a),
    .btn_b   (btn_b),
    .btn_calc(btn_calc),
    .switch  (switch),
    .data_o  (data_o),
    .lvl_o   (lvl_o),
    .sw_o    (sw_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance n clk edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus read cycle: check data_o before the edge, then drop ce.
  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    ce = 1'b1; we = 1'b0; addr = a;
    #1;
    chk(name, data_o, exp);
    step(1);
    ce = 1'b0; addr = '0;
  endtask

  initial begin
    bit found;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0001};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0024, 32'h0000_0000};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0028, 32'h0000_0001};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_002c, 32'h0000_A5C3};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_002e, 32'h0000_A5C3};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0023, 32'h0000_0001};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0060, 32'h0000_0001};
    vecs[7]  = '{1'b1, 1'b0, 32'hFFFF_FFEC, 32'h0000_A5C3};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0030, 32'h0000_0000};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_001c, 32'h0000_0000};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_003c, 32'h0000_0000};
    vecs[12] = '{1'b0, 1'b0, 32'h0000_002c, 32'h0000_0000};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_002c, 32'h0000_0000};

    rst = 1'b0; ce = 1'b0; we = 1'b0; addr = '0;
    btn_a = 1'b1; btn_b = 1'b0; btn_calc = 1'b0; switch = '0;

    // 1: reset, including a reset in the middle of a debounce count
    step(3);
    ce = 1'b1; addr = 32'h20;
    #1;
    chk("reset_lvl", 32'(lvl_o), 32'h0);
    chk("reset_data", data_o, 32'h0);
    chk("reset_sw", 32'(sw_o), 32'h0);
    ce = 1'b0;
    rst = 1'b1;
    step(6);
    ce = 1'b1; addr = 32'h20;
    rst = 1'b0;
    #1;
    chk("midrst_lvl", 32'(lvl_o), 32'h0);
    chk("midrst_data", data_o, 32'h0);
    step(2);
    ce = 1'b0; addr = '0;
    rst = 1'b1;
    step(11);
    chk("rel_lvl_early", 32'(lvl_o[0]), 32'h0);
    step(3);
    chk("rel_lvl_by_14", 32'(lvl_o[0]), 32'h1);

    // 3: press and clear-on-read
    rd_chk("a_rd1", 32'h20, 32'h3);
    rd_chk("a_rd2", 32'h20, 32'h1);
    btn_a = 1'b0;
    step(80);
    rd_chk("a_released", 32'h20, 32'h0);
    btn_a = 1'b1;
    step(80);
    rd_chk("a_press_rd1", 32'h20, 32'h3);
    rd_chk("a_press_rd2", 32'h20, 32'h1);
    btn_a = 1'b0;
    step(80);
    rd_chk("a_press_rel", 32'h20, 32'h0);

    // 6: gated accesses neither return data nor clear the event
    btn_a = 1'b1;
    step(80);
    ce = 1'b0; we = 1'b0; addr = 32'h20;
    #1;
    chk("gate_ce0", data_o, 32'h0);
    step(1);
    ce = 1'b1; we = 1'b1; addr = 32'h20;
    #1;
    chk("gate_we1", data_o, 32'h0);
    step(1);
    ce = 1'b1; we = 1'b0; addr = 32'h30;
    #1;
    chk("gate_unmapped", data_o, 32'h0);
    step(1);
    ce = 1'b0; we = 1'b0; addr = '0;
    rd_chk("gate_evt_kept", 32'h20, 32'h3);
    rd_chk("gate_evt_clr", 32'h20, 32'h1);

    // 2: bounce rejection on btn_b (2 ticks high, 1 tick low)
    for (int r = 0; r < 5; r++) begin
      btn_b = 1'b1;
      step(8);
      btn_b = 1'b0;
      step(4);
      chk($sformatf("bounce_lvl%0d", r), 32'(lvl_o[1]), 32'h0);
    end
    step(20);
    rd_chk("bounce_rd", 32'h24, 32'h0);

    // 4: read lands on the clk where calc_stable first reads 1
    chk("calc_idle", 32'(lvl_o[2]), 32'h0);
    btn_calc = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      step(1);
      if (lvl_o[2]) found = 1'b1;
    end
    if (!found) begin
      n_chk++; n_fail++;
      $display("FAIL calc_rise_timeout: got lvl_o=%b required bit2=1 within 100 clk", lvl_o);
    end else begin
      rd_chk("collide_rd1", 32'h28, 32'h1);
      rd_chk("collide_rd2", 32'h28, 32'h3);
      rd_chk("collide_rd3", 32'h28, 32'h1);
    end

    // 5: switch word
    switch = 16'hA5C3;
    step(80);
    chk("sw_lvl", 32'(sw_o), 32'h0000_A5C3);
    rd_chk("sw_rd1", 32'h2e, 32'h0000_A5C3);
    rd_chk("sw_rd2", 32'h2e, 32'h0000_A5C3);

    // Read-map table: a=1, b=0, calc=1, no pending events, switch=A5C3
    chk("tbl_lvl", 32'(lvl_o), 32'h5);
    for (int i = 0; i < 14; i++) begin
      ce = vecs[i].ce; we = vecs[i].we; addr = vecs[i].addr;
      #1;
      chk($sformatf("tbl%0d_addr%08h", i, vecs[i].addr), data_o, vecs[i].exp);
      step(1);
    end
    ce = 1'b0; we = 1'b0; addr = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
